uart_tx: RTL



---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_fifo.sv | 43 ++++
 rtl/uart_tx.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states and baud timing helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction
  function automatic int baud_cnt_w(input int clk_freq, input int uart_bps);
    return baud_cnt_max(clk_freq, uart_bps) > 1 ? $clog2(baud_cnt_max(clk_freq, uart_bps)) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the transmitter
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge sys_clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, LSB first, optional parity, 1 or 2 stop bits
module uart_tx import uart_pkg::*; #(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       pi_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BAUD_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int CW = baud_cnt_w(CLK_FREQ, UART_BPS);
  state_e state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, dout;
  logic par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic full, empty, pop, bit_end, last_stop, unused_count;
  logic [$clog2(FIFO_DEPTH):0] count;
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .push(pi_flag), .pop(pop), .din(pi_data),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  assign unused_count = ^count;
  assign pi_ready = !full;
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  always_comb begin
    bit_end = baud_q == CW'(BAUD_MAX - 1);
    last_stop = bit_q == 3'(STOP_BITS - 1);
    pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end && last_stop));
    state_d = state_q;
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = pop ? dout : shift_q;
    par_d = pop ? (^dout) ^ 1'(PARITY_ODD) : par_q;
    case (state_q)
      IDLE:   if (pop) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) begin
        bit_d = last_stop ? '0 : bit_q + 3'd1;
        if (last_stop) state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // line value follows the current state, so it lags the state by one cycle
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
    busy_d = state_q != IDLE;
    done_d = state_q == STOP && bit_end && last_stop;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
